// File: rtl/ttt_game_ctrl_pkg.sv
// Shared types, constants and the win-line table for the tic-tac-toe controller.
// Square index is row-major: 0 = top-left, 8 = bottom-right.
package ttt_game_ctrl_pkg;

    localparam int NUM_SQUARES = 9;
    localparam int NUM_LINES   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_O    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    // Line l is won when all three listed squares belong to one player.
    // Order matches the win_line bit positions.
    localparam logic [3:0] LINE_SQ [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // One-hot square mask; positions off the board map to an empty mask.
    function automatic logic [NUM_SQUARES-1:0] square_mask(input logic [3:0] pos);
        if (pos < 4'(NUM_SQUARES)) begin
            square_mask = NUM_SQUARES'(1) << pos;
        end else begin
            square_mask = '0;
        end
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win-line detector: flags every line fully occupied on one board.
module ttt_line_check
    import ttt_game_ctrl_pkg::*;
(
    input  logic [NUM_SQUARES-1:0] board_i,
    output logic [NUM_LINES-1:0]   lines_o
);

    always_comb begin
        lines_o = '0;
        for (int l = 0; l < NUM_LINES; l++) begin
            lines_o[l] = board_i[LINE_SQ[l][0]]
                       & board_i[LINE_SQ[l][1]]
                       & board_i[LINE_SQ[l][2]];
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: accepts moves, keeps the X/O boards, detects win/draw.
// Optional single-level undo is enabled by defining TTT_UNDO_EN.
//
// Handshake: a move transfers on a rising edge where move_valid & move_ready;
// move_ready is high only in PLAY, move_valid is ignored in every other state,
// and move_pos must be stable while move_valid is high.
module ttt_game_ctrl
    import ttt_game_ctrl_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   move_valid,
    input  logic [3:0]             move_pos,
`ifdef TTT_UNDO_EN
    input  logic                   undo,
`endif
    output logic                   move_ready,
    output logic [NUM_SQUARES-1:0] xboard,
    output logic [NUM_SQUARES-1:0] oboard,
    output logic                   turn,
    output logic                   illegal,
    output logic                   game_over,
    output logic [1:0]             winner,
    output logic [NUM_LINES-1:0]   win_line,
    output logic [1:0]             dbg_state_o,
    output logic [3:0]             dbg_move_cnt_o
);

    state_e                 state_q,    state_d;
    logic [NUM_SQUARES-1:0] xboard_q,   xboard_d;
    logic [NUM_SQUARES-1:0] oboard_q,   oboard_d;
    logic                   turn_q,     turn_d;
    logic [3:0]             move_cnt_q, move_cnt_d;
    winner_e                winner_q,   winner_d;
    logic [NUM_LINES-1:0]   win_line_q, win_line_d;
    logic                   illegal_q,  illegal_d;

`ifdef TTT_UNDO_EN
    logic [3:0]             last_pos_q,   last_pos_d;
    logic                   last_valid_q, last_valid_d;
    logic                   undo_mover;
    logic                   undo_ok;
`endif

    logic [NUM_SQUARES-1:0] occupied;
    logic [NUM_SQUARES-1:0] move_mask;
    logic                   move_legal;
    logic [NUM_SQUARES-1:0] mover_board;
    logic [NUM_LINES-1:0]   line_flags;

    assign occupied   = xboard_q | oboard_q;
    assign move_mask  = square_mask(move_pos);
    assign move_legal = (move_pos < 4'(NUM_SQUARES)) && ((occupied & move_mask) == '0);

    // turn is only toggled after EVAL, so in EVAL it still names the mover.
    assign mover_board = turn_q ? oboard_q : xboard_q;

    ttt_line_check u_line_check (
        .board_i (mover_board),
        .lines_o (line_flags)
    );

`ifdef TTT_UNDO_EN
    // In DONE the turn was never toggled; in PLAY it already points past the mover.
    assign undo_mover = (state_q == DONE) ? turn_q : ~turn_q;
    assign undo_ok    = last_valid_q && ((state_q == DONE) || (move_cnt_q != 4'd0));
`endif

    always_comb begin
        state_d    = state_q;
        xboard_d   = xboard_q;
        oboard_d   = oboard_q;
        turn_d     = turn_q;
        move_cnt_d = move_cnt_q;
        winner_d   = winner_q;
        win_line_d = win_line_q;
        illegal_d  = 1'b0;
`ifdef TTT_UNDO_EN
        last_pos_d   = last_pos_q;
        last_valid_d = last_valid_q;
`endif

        if (start) begin
            state_d    = PLAY;
            xboard_d   = '0;
            oboard_d   = '0;
            turn_d     = FIRST_PLAYER;
            move_cnt_d = 4'd0;
            winner_d   = WIN_NONE;
            win_line_d = '0;
`ifdef TTT_UNDO_EN
            last_valid_d = 1'b0;
`endif
        end
`ifdef TTT_UNDO_EN
        else if (undo && ((state_q == PLAY) || (state_q == DONE))) begin
            if (undo_ok) begin
                if (undo_mover) begin
                    oboard_d = oboard_q & ~square_mask(last_pos_q);
                end else begin
                    xboard_d = xboard_q & ~square_mask(last_pos_q);
                end
                move_cnt_d   = move_cnt_q - 4'd1;
                turn_d       = undo_mover;
                winner_d     = WIN_NONE;
                win_line_d   = '0;
                last_valid_d = 1'b0;
                state_d      = PLAY;
            end else begin
                illegal_d = 1'b1;
            end
        end
`endif
        else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                PLAY: begin
                    if (move_valid) begin
                        if (move_legal) begin
                            if (turn_q) begin
                                oboard_d = oboard_q | move_mask;
                            end else begin
                                xboard_d = xboard_q | move_mask;
                            end
                            move_cnt_d = move_cnt_q + 4'd1;
                            state_d    = EVAL;
`ifdef TTT_UNDO_EN
                            last_pos_d   = move_pos;
                            last_valid_d = 1'b1;
`endif
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                EVAL: begin
                    if (line_flags != '0) begin
                        win_line_d = line_flags;
                        winner_d   = turn_q ? WIN_O : WIN_X;
                        state_d    = DONE;
                    end else if (move_cnt_q == 4'(NUM_SQUARES)) begin
                        win_line_d = '0;
                        winner_d   = WIN_DRAW;
                        state_d    = DONE;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = PLAY;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            xboard_q   <= '0;
            oboard_q   <= '0;
            turn_q     <= FIRST_PLAYER;
            move_cnt_q <= 4'd0;
            winner_q   <= WIN_NONE;
            win_line_q <= '0;
            illegal_q  <= 1'b0;
`ifdef TTT_UNDO_EN
            last_pos_q   <= 4'd0;
            last_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            xboard_q   <= xboard_d;
            oboard_q   <= oboard_d;
            turn_q     <= turn_d;
            move_cnt_q <= move_cnt_d;
            winner_q   <= winner_d;
            win_line_q <= win_line_d;
            illegal_q  <= illegal_d;
`ifdef TTT_UNDO_EN
            last_pos_q   <= last_pos_d;
            last_valid_q <= last_valid_d;
`endif
        end
    end

    assign move_ready     = (state_q == PLAY);
    assign game_over      = (state_q == DONE);
    assign xboard         = xboard_q;
    assign oboard         = oboard_q;
    assign turn           = turn_q;
    assign illegal        = illegal_q;
    assign winner         = winner_q;
    assign win_line       = win_line_q;
    assign dbg_state_o    = state_q;
    assign dbg_move_cnt_o = move_cnt_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: two instances (X first, O first) share one stimulus
// stream and are scored against a board-level game model kept in the bench.
module tb_ttt_game_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       move_valid;
    logic [3:0] move_pos;
`ifdef TTT_UNDO_EN
    logic       undo;
`endif

    logic [8:0] xb   [2];
    logic [8:0] ob   [2];
    logic       trn  [2];
    logic       ill  [2];
    logic       gov  [2];
    logic       mrdy [2];
    logic [1:0] win  [2];
    logic [7:0] wl   [2];
    logic [1:0] st   [2];
    logic [3:0] mc   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ttt_game_ctrl #(.FIRST_PLAYER(1'(g))) u_dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start),
            .move_valid     (move_valid),
            .move_pos       (move_pos),
`ifdef TTT_UNDO_EN
            .undo           (undo),
`endif
            .move_ready     (mrdy[g]),
            .xboard         (xb[g]),
            .oboard         (ob[g]),
            .turn           (trn[g]),
            .illegal        (ill[g]),
            .game_over      (gov[g]),
            .winner         (win[g]),
            .win_line       (wl[g]),
            .dbg_state_o    (st[g]),
            .dbg_move_cnt_o (mc[g])
        );
    end

    // ---------------- reference model ----------------
    // cells: 0 empty, 1 first mover, 2 second mover. Player of mover k in
    // instance d is k ^ d (0 = X, 1 = O).
    int cells [9];
    int line_tab [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                            '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int mcnt;
    int cur;        // mover index to play next
    int result;     // 0 none, 1 first mover won, 2 second mover won, 3 draw
    int exp_wl;
    int phase;      // 0 idle, 1 play, 2 eval, 3 done
    bit exp_ill;
    int last_pos;
    int last_mover;
    bit last_ok;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] exp_board(input int d, input int player);
        logic [8:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) begin
            if (cells[i] != 0 && (((cells[i] - 1) ^ d) == player)) b[i] = 1'b1;
        end
        return b;
    endfunction

    function automatic int exp_winner(input int d);
        if (result == 0) return 0;
        if (result == 3) return 3;
        return (((result - 1) ^ d) == 0) ? 1 : 2;
    endfunction

    task automatic check_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("%s d%0d xboard", tag, d), 32'(xb[d]), 32'(exp_board(d, 0)));
            check_val($sformatf("%s d%0d oboard", tag, d), 32'(ob[d]), 32'(exp_board(d, 1)));
            check_val($sformatf("%s d%0d turn", tag, d), 32'(trn[d]), 32'((cur ^ d) & 1));
            check_val($sformatf("%s d%0d winner", tag, d), 32'(win[d]), 32'(exp_winner(d)));
            check_val($sformatf("%s d%0d win_line", tag, d), 32'(wl[d]), 32'(exp_wl));
            check_val($sformatf("%s d%0d game_over", tag, d), 32'(gov[d]), 32'(phase == 3));
            check_val($sformatf("%s d%0d move_ready", tag, d), 32'(mrdy[d]), 32'(phase == 1));
            check_val($sformatf("%s d%0d illegal", tag, d), 32'(ill[d]), 32'(exp_ill));
            check_val($sformatf("%s d%0d state", tag, d), 32'(st[d]), 32'(phase));
            check_val($sformatf("%s d%0d move_cnt", tag, d), 32'(mc[d]), 32'(mcnt));
        end
    endtask

    task automatic model_clear(input int ph);
        for (int i = 0; i < 9; i++) cells[i] = 0;
        mcnt    = 0;
        cur     = 0;
        result  = 0;
        exp_wl  = 0;
        exp_ill = 1'b0;
        last_ok = 1'b0;
        phase   = ph;
    endtask

    // Decide the outcome of the move just placed by mover `cur`.
    task automatic model_eval();
        int flags;
        flags = 0;
        for (int l = 0; l < 8; l++) begin
            if (cells[line_tab[l][0]] == cur + 1 && cells[line_tab[l][1]] == cur + 1 &&
                cells[line_tab[l][2]] == cur + 1) flags |= (1 << l);
        end
        if (flags != 0) begin
            result = cur + 1;
            exp_wl = flags;
            phase  = 3;
        end else if (mcnt == 9) begin
            result = 3;
            exp_wl = 0;
            phase  = 3;
        end else begin
            cur   = cur ^ 1;
            phase = 1;
        end
    endtask

    // ---------------- driver tasks (entered just after a falling edge) ----------------
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear(0);
        check_all("reset");
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_clear(1);
        check_all("start");
    endtask

    task automatic do_move(input int pos);
        move_valid = 1'b1;
        move_pos   = 4'(pos);
        @(negedge clk);
        move_valid = 1'b0;
        if (phase == 1) begin
            if (pos <= 8 && cells[pos] == 0) begin
                cells[pos] = cur + 1;
                mcnt++;
                last_pos   = pos;
                last_mover = cur;
                last_ok    = 1'b1;
                phase      = 2;
                check_all("accept");
                @(negedge clk);
                model_eval();
                check_all("eval");
            end else begin
                exp_ill = 1'b1;
                check_all("reject");
                exp_ill = 1'b0;
            end
        end else begin
            check_all("ignored");
        end
    endtask

`ifdef TTT_UNDO_EN
    task automatic do_undo();
        undo = 1'b1;
        @(negedge clk);
        undo = 1'b0;
        if (phase == 1 || phase == 3) begin
            if (last_ok) begin
                cells[last_pos] = 0;
                mcnt--;
                cur     = last_mover;
                result  = 0;
                exp_wl  = 0;
                last_ok = 1'b0;
                phase   = 1;
            end else begin
                exp_ill = 1'b1;
            end
        end
        check_all("undo");
        exp_ill = 1'b0;
    endtask
`endif

    // ---------------- stimulus ----------------
    int seq_win  [5] = '{0, 3, 1, 4, 2};
    int seq_draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int seq_diag [5] = '{0, 1, 4, 2, 8};

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        move_valid = 1'b0;
        move_pos   = 4'd0;
`ifdef TTT_UNDO_EN
        undo       = 1'b0;
`endif
        @(negedge clk);
        do_reset();
        do_move(4);                       // ignored in IDLE

        // row 0 win for the first mover
        do_start();
        foreach (seq_win[i]) do_move(seq_win[i]);
        check_val("row0 xboard", 32'(xb[0]), 32'h007);
        check_val("row0 oboard", 32'(ob[0]), 32'h018);
        check_val("row0 winner", 32'(win[0]), 32'h1);
        check_val("row0 win_line", 32'(wl[0]), 32'h01);
        do_move(5);                       // ignored in DONE
`ifdef TTT_UNDO_EN
        do_undo();
        check_val("undo xboard", 32'(xb[0]), 32'h003);
        check_val("undo turn", 32'(trn[0]), 32'h0);
        do_undo();                        // second level is refused
`endif

        // illegal moves: occupied square, then off-board index
        do_start();
        do_move(4);
        do_move(4);
        do_move(9);
        check_val("illegal turn", 32'(trn[0]), 32'h1);

        // full-board draw
        do_start();
        foreach (seq_draw[i]) do_move(seq_draw[i]);
        check_val("draw winner", 32'(win[0]), 32'h3);
        check_val("draw xboard", 32'(xb[0]), 32'h18D);
        check_val("draw move_cnt", 32'(mc[0]), 32'd9);

        // diagonal win; instance 1 has O moving first
        do_start();
        foreach (seq_diag[i]) do_move(seq_diag[i]);
        check_val("diag winner", 32'(win[1]), 32'h2);
        check_val("diag win_line", 32'(wl[1]), 32'h40);

        // reset landing on the EVAL cycle
        do_start();
        do_move(0);
        do_move(3);
        move_valid = 1'b1;
        move_pos   = 4'd1;
        @(negedge clk);
        move_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear(0);
        check_all("rst_eval");

        // random games, with occasional off-board indices and restarts
        for (int g = 0; g < 60; g++) begin
            do_start();
            for (int j = 0; j < 30; j++) begin
                if (phase == 3) break;
                if ($urandom_range(0, 99) < 15) do_move(int'($urandom_range(9, 15)));
                else do_move(int'($urandom_range(0, 8)));
                if ($urandom_range(0, 99) < 2) break;
            end
            if ($urandom_range(0, 1) == 1) do_move(int'($urandom_range(0, 8)));
        end
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
